ad_ip_jesd204_tpl_adc_regmap_v2: RTL and testbench

Parametrised register bank for the JESD204 ADC transport layer. It sits on the internal up bus (up_wreq/up_rreq word interface), downstream of the AXI bridge, and drives per-channel data-format and PN-monitor controls. Over the previous single-profile map it adds sticky write-1-to-clear status, saturating per-channel PN error counters, and a staged profile-switch handshake. Everything runs in one clock domain; status inputs arrive already synchronised to up_clk.

---
 rtl/ad_ip_jesd204_tpl_adc_regmap_v2.sv | 213 +++++++++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_adc_regmap_v2.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ad_ip_jesd204_tpl_adc_regmap_v2.sv
`default_nettype none
// ============================================================================
// Module   : ad_ip_jesd204_tpl_adc_regmap_v2
// Purpose  : Register bank for the JESD204 ADC transport layer on the up bus.
//            Per-channel data-format / PN-monitor controls, sticky
//            write-1-to-clear status, saturating PN error counters and a
//            staged profile-switch handshake.
// Ports    : up_clk/up_rst            clock, async active-high reset
//            up_wreq/waddr/wdata/wack write channel (word addressed)
//            up_rreq/raddr/rdata/rack read channel (rdata 0 unless acked)
//            enable, dfmt_*, pn_seq_sel  per-channel controls
//            pn_err, pn_oos, adc_dovf    status inputs (already in up_clk)
//            profile_sel/update/ack      profile switch handshake
// Revision : 2.0 - sticky status, error counters, profile FSM
// ============================================================================
module ad_ip_jesd204_tpl_adc_regmap_v2 #(
  parameter int          NUM_CHANNELS = 4,
  parameter int          NUM_PROFILES = 1,
  parameter int          CNT_WIDTH    = 16,
  parameter logic [31:0] VERSION      = 32'h0002_0000
) (
  input  logic                      up_clk,
  input  logic                      up_rst,
  input  logic                      up_wreq,
  input  logic [9:0]                up_waddr,
  input  logic [31:0]               up_wdata,
  output logic                      up_wack,
  input  logic                      up_rreq,
  input  logic [9:0]                up_raddr,
  output logic [31:0]               up_rdata,
  output logic                      up_rack,
  output logic [NUM_CHANNELS-1:0]   enable,
  output logic [NUM_CHANNELS-1:0]   dfmt_enable,
  output logic [NUM_CHANNELS-1:0]   dfmt_sign_extend,
  output logic [NUM_CHANNELS-1:0]   dfmt_type,
  output logic [4*NUM_CHANNELS-1:0] pn_seq_sel,
  input  logic [NUM_CHANNELS-1:0]   pn_err,
  input  logic [NUM_CHANNELS-1:0]   pn_oos,
  input  logic                      adc_dovf,
  output logic [7:0]                profile_sel,
  output logic                      profile_update,
  input  logic                      profile_ack
);

  localparam int                   c_ch_end  = 16 + 4 * NUM_CHANNELS;
  localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  // address decode
  logic       w_wr_top, w_wr_ch, w_rd_top, w_rd_ch;
  logic [7:0] w_wch, w_rch;

  assign w_wr_top = (up_waddr <= 10'd4);
  assign w_wr_ch  = (up_waddr >= 10'h010) && ({1'b0, up_waddr} < 11'(c_ch_end));
  assign w_rd_top = (up_raddr <= 10'd4);
  assign w_rd_ch  = (up_raddr >= 10'h010) && ({1'b0, up_raddr} < 11'(c_ch_end));
  // channel bases are 4-aligned from 0x010, so the index is addr[9:2]-4
  assign w_wch    = up_waddr[9:2] - 8'd4;
  assign w_rch    = up_raddr[9:2] - 8'd4;

  // global registers
  logic [31:0] r_scratch;
  logic [7:0]  r_pend;
  logic        r_ovf, r_rej;
  logic        w_w1c_top;
  logic        w_reject;

  assign w_w1c_top = up_wreq && (up_waddr == 10'd4);

  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      r_scratch <= '0;
      r_pend    <= '0;
      r_ovf     <= 1'b0;
      r_rej     <= 1'b0;
      up_wack   <= 1'b0;
    end else begin
      if (up_wreq && (up_waddr == 10'd1)) r_scratch <= up_wdata;
      if (up_wreq && (up_waddr == 10'd2)) r_pend    <= up_wdata[7:0];
      // a new event in the same cycle as the clear keeps the bit set
      r_ovf   <= adc_dovf | (r_ovf & ~(w_w1c_top & up_wdata[0]));
      r_rej   <= w_reject | (r_rej & ~(w_w1c_top & up_wdata[1]));
      up_wack <= up_wreq & (w_wr_top | w_wr_ch);
    end
  end

  // per-channel registers
  logic [7:0]           w_ctrl   [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0] w_cnt    [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] w_err_st, w_oos_st;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [7:0]           r_ctrl;
    logic                 r_err_st, r_oos_st;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_sel;

    assign w_sel = up_wreq && w_wr_ch && (w_wch == 8'(i));

    always_ff @(posedge up_clk or posedge up_rst) begin
      if (up_rst) begin
        r_ctrl   <= '0;
        r_err_st <= 1'b0;
        r_oos_st <= 1'b0;
        r_cnt    <= '0;
      end else begin
        if (w_sel && (up_waddr[1:0] == 2'd0)) r_ctrl <= up_wdata[7:0];
        r_err_st <= pn_err[i] | (r_err_st & ~(w_sel && (up_waddr[1:0] == 2'd1) && up_wdata[0]));
        r_oos_st <= pn_oos[i] | (r_oos_st & ~(w_sel && (up_waddr[1:0] == 2'd1) && up_wdata[2]));
        // clear wins over the old count but not over an error in the same cycle
        if (w_sel && (up_waddr[1:0] == 2'd2))
          r_cnt <= pn_err[i] ? CNT_WIDTH'(1) : '0;
        else if (pn_err[i] && (r_cnt != c_cnt_max))
          r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end

    assign w_ctrl[i]          = r_ctrl;
    assign w_cnt[i]           = r_cnt;
    assign w_err_st[i]        = r_err_st;
    assign w_oos_st[i]        = r_oos_st;
    assign enable[i]           = r_ctrl[0];
    assign dfmt_enable[i]      = r_ctrl[1];
    assign dfmt_sign_extend[i] = r_ctrl[2];
    assign dfmt_type[i]        = r_ctrl[3];
    assign pn_seq_sel[4*i +: 4] = r_ctrl[7:4];
  end

  // profile switch FSM
  state_t     r_state, w_state_nxt;
  logic [7:0] w_sel_nxt;
  logic       w_update_nxt;
  logic       w_commit;

  assign w_commit = up_wreq && (up_waddr == 10'd3) && up_wdata[0];

  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      r_state        <= ST_IDLE;
      profile_sel    <= '0;
      profile_update <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      profile_sel    <= w_sel_nxt;
      profile_update <= w_update_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = profile_sel;
    w_update_nxt = 1'b0;
    w_reject     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_commit) begin
          if ({1'b0, r_pend} < 9'(NUM_PROFILES)) begin
            w_sel_nxt    = r_pend;
            w_update_nxt = 1'b1;
            w_state_nxt  = ST_BUSY;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (profile_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // read path
  logic [31:0] w_rval;

  always_comb begin
    w_rval = '0;
    if (w_rd_top) begin
      case (up_raddr[2:0])
        3'd0:    w_rval = VERSION;
        3'd1:    w_rval = r_scratch;
        3'd2:    w_rval = {24'd0, r_pend};
        3'd3:    w_rval = {16'd0, profile_sel, 7'd0, (r_state == ST_BUSY)};
        3'd4:    w_rval = {29'd0, |w_err_st, r_rej, r_ovf};
        default: w_rval = '0;
      endcase
    end else if (w_rd_ch) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (w_rch == 8'(i)) begin
          case (up_raddr[1:0])
            2'd0:    w_rval = {24'd0, w_ctrl[i]};
            2'd1:    w_rval = {29'd0, w_oos_st[i], pn_oos[i], w_err_st[i]};
            2'd2:    w_rval = 32'(w_cnt[i]);
            default: w_rval = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      up_rack  <= 1'b0;
      up_rdata <= '0;
    end else begin
      up_rack  <= up_rreq & (w_rd_top | w_rd_ch);
      up_rdata <= (up_rreq & (w_rd_top | w_rd_ch)) ? w_rval : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ad_ip_jesd204_tpl_adc_regmap_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad_ip_jesd204_tpl_adc_regmap_v2
// Purpose  : Self-checking bench; reads push expected data into a scoreboard
//            queue, a monitor pops and compares on every read acknowledge.
// Revision : 2.0
// ============================================================================
module tb_ad_ip_jesd204_tpl_adc_regmap_v2;

  logic        up_clk = 1'b0;
  logic        up_rst = 1'b1;
  logic        up_wreq = 1'b0;
  logic [9:0]  up_waddr = '0;
  logic [31:0] up_wdata = '0;
  logic        up_wack;
  logic        up_rreq = 1'b0;
  logic [9:0]  up_raddr = '0;
  logic [31:0] up_rdata;
  logic        up_rack;
  logic [3:0]  enable, dfmt_enable, dfmt_sign_extend, dfmt_type;
  logic [15:0] pn_seq_sel;
  logic [3:0]  pn_err = '0;
  logic [3:0]  pn_oos = '0;
  logic        adc_dovf = 1'b0;
  logic [7:0]  profile_sel;
  logic        profile_update;
  logic        profile_ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q_exp[$];
  string       q_name[$];

  ad_ip_jesd204_tpl_adc_regmap_v2 #(
    .NUM_CHANNELS(4), .NUM_PROFILES(2), .CNT_WIDTH(2), .VERSION(32'h0002_0000)
  ) dut (
    .up_clk(up_clk), .up_rst(up_rst),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
    .enable(enable), .dfmt_enable(dfmt_enable), .dfmt_sign_extend(dfmt_sign_extend),
    .dfmt_type(dfmt_type), .pn_seq_sel(pn_seq_sel),
    .pn_err(pn_err), .pn_oos(pn_oos), .adc_dovf(adc_dovf),
    .profile_sel(profile_sel), .profile_update(profile_update), .profile_ack(profile_ack)
  );

  always #5 up_clk = ~up_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge up_clk) begin
    if (up_rack) begin
      if (q_exp.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rack: got rdata 0x%08h expected no ack", up_rdata);
      end else begin
        chk(q_name.pop_front(), up_rdata, q_exp.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge up_clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    up_wreq = 1'b1; up_waddr = a; up_wdata = d;
    cyc();
    up_wreq = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] exp, input string name);
    up_rreq = 1'b1; up_raddr = a;
    q_exp.push_back(exp);
    q_name.push_back(name);
    cyc();
    up_rreq = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    cyc(); cyc();
    chk("rst_outputs", {enable, dfmt_enable, dfmt_sign_extend, dfmt_type, pn_seq_sel}, 32'd0);
    chk("rst_profile", {22'd0, profile_update, up_wack, profile_sel}, 32'd0);
    chk("rst_read", {up_rack, up_rdata[30:0]}, 32'd0);
    up_rst = 1'b0;
    cyc();

    rd(10'h000, 32'h0002_0000, "version");
    rd(10'h001, 32'd0, "scratch_rst");
    rd(10'h010, 32'd0, "ch0_ctrl_rst");
    rd(10'h011, 32'd0, "ch0_status_rst");

    // channel control
    wr(10'h010, 32'h0000_00F3);
    chk("wack", {31'd0, up_wack}, 32'd1);
    chk("ch0_ctrl_out", {enable, dfmt_enable, dfmt_sign_extend, dfmt_type, pn_seq_sel},
        {4'b0001, 4'b0001, 4'b0000, 4'b0000, 16'h000F});
    cyc();
    chk("wack_drop", {31'd0, up_wack}, 32'd0);
    rd(10'h010, 32'h0000_00F3, "ch0_ctrl_rd");

    // unmapped accesses
    up_rreq = 1'b1; up_raddr = 10'h030;
    cyc();
    up_rreq = 1'b0;
    chk("unmapped_rd", {up_rack, up_rdata[30:0]}, 32'd0);
    wr(10'h005, 32'hFFFF_FFFF);
    chk("unmapped_wack", {31'd0, up_wack}, 32'd0);

    wr(10'h001, 32'hDEAD_BEEF);
    rd(10'h001, 32'hDEAD_BEEF, "scratch_rw");

    // saturating error counter on channel 1
    pn_err = 4'b0010;
    repeat (5) cyc();
    pn_err = 4'b0000;
    rd(10'h016, 32'd3, "errcnt_sat");
    rd(10'h015, 32'd1, "ch1_err_sticky");
    rd(10'h004, 32'd4, "status_pn_or");
    pn_err = 4'b0010;
    wr(10'h016, 32'd0);
    pn_err = 4'b0000;
    rd(10'h016, 32'd1, "errcnt_clr_vs_err");
    wr(10'h015, 32'd1);
    rd(10'h015, 32'd0, "ch1_err_w1c");

    // pn_oos live and sticky on channel 2
    pn_oos = 4'b0100;
    cyc();
    rd(10'h019, 32'd6, "ch2_oos_live");
    pn_oos = 4'b0000;
    rd(10'h019, 32'd4, "ch2_oos_sticky");
    wr(10'h019, 32'd4);
    rd(10'h019, 32'd0, "ch2_oos_w1c");

    // overflow sticky with clear/event collision
    adc_dovf = 1'b1;
    cyc();
    adc_dovf = 1'b0;
    rd(10'h004, 32'd1, "ovf_set");
    adc_dovf = 1'b1;
    wr(10'h004, 32'd1);
    adc_dovf = 1'b0;
    rd(10'h004, 32'd1, "ovf_clr_vs_event");
    wr(10'h004, 32'd1);
    rd(10'h004, 32'd0, "ovf_cleared");

    // profile switch
    wr(10'h002, 32'd1);
    rd(10'h002, 32'd1, "profile_pend");
    wr(10'h003, 32'd1);
    chk("commit_sel_pulse", {23'd0, profile_update, profile_sel}, {23'd0, 1'b1, 8'd1});
    cyc();
    chk("pulse_one_cycle", {31'd0, profile_update}, 32'd0);
    rd(10'h003, 32'h0000_0101, "busy_set");
    wr(10'h003, 32'd1);
    chk("busy_commit_no_pulse", {23'd0, profile_update, profile_sel}, {23'd0, 1'b0, 8'd1});
    profile_ack = 1'b1;
    cyc();
    profile_ack = 1'b0;
    rd(10'h003, 32'h0000_0100, "ack_idle");

    // ack in the same cycle as a commit does not end BUSY
    profile_ack = 1'b1;
    wr(10'h003, 32'd1);
    profile_ack = 1'b0;
    chk("recommit_pulse", {31'd0, profile_update}, 32'd1);
    rd(10'h003, 32'h0000_0101, "ack_same_cycle_ignored");
    profile_ack = 1'b1;
    cyc();
    profile_ack = 1'b0;

    // out-of-range commit
    wr(10'h002, 32'd2);
    wr(10'h003, 32'd1);
    chk("reject_no_pulse", {23'd0, profile_update, profile_sel}, {23'd0, 1'b0, 8'd1});
    rd(10'h004, 32'd2, "reject_sticky");
    rd(10'h003, 32'h0000_0100, "reject_stays_idle");

    // async reset mid-BUSY
    wr(10'h002, 32'd1);
    wr(10'h003, 32'd1);
    up_rst = 1'b1;
    #1;
    chk("async_rst", {15'd0, enable, profile_update, profile_sel, 4'd0}, 32'd0);
    cyc();
    up_rst = 1'b0;
    cyc();
    rd(10'h003, 32'd0, "busy_after_rst");
    rd(10'h010, 32'd0, "ctrl_after_rst");

    cyc(); cyc();
    chk("scoreboard_drained", q_exp.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
